// File: rtl/effect_pkg.sv
// Shared state codes, LED patterns and default reset levels for the effect parameter controller.
package effect_pkg;

  typedef enum logic [2:0] {
    StI2c  = 3'd0,
    StPlay = 3'd1,
    StSet  = 3'd2,
    StRecd = 3'd3,
    StLoop = 3'd4
  } state_e;

  localparam logic [8:0] LedI2c  = 9'h100;
  localparam logic [8:0] LedPlay = 9'h001;
  localparam logic [8:0] LedSet  = 9'h002;
  localparam logic [8:0] LedRecd = 9'h004;
  localparam logic [8:0] LedLoop = 9'h008;

  localparam int unsigned MaxRstBits = 256;

  // Slots 3 and 4 start at level 3 (truncated if PARAM_W < 2), everything else at 0.
  function automatic logic [MaxRstBits-1:0] rst_default(input int num_eff, input int param_w);
    logic [MaxRstBits-1:0] v;
    v = '0;
    for (int k = 3; k <= 4; k++) begin
      if (k < num_eff) begin
        for (int b = 0; b < 2; b++) begin
          if (b < param_w) v[k*param_w+b] = 1'b1;
        end
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/param_step.sv
// Single-slot level step: +1 / -1 with wrap-around or saturation; inc and dec together cancel.
module param_step #(
  parameter int unsigned PARAM_W = 3,
  parameter bit          SAT     = 1'b0
) (
  input  logic [PARAM_W-1:0] level,
  input  logic               inc,
  input  logic               dec,
  output logic [PARAM_W-1:0] level_next
);

  localparam logic [PARAM_W-1:0] LevelMax = '1;

  always_comb begin
    level_next = level;
    if (inc && !dec) begin
      if (!(SAT && level == LevelMax)) level_next = level + PARAM_W'(1);
    end else if (dec && !inc) begin
      if (!(SAT && level == '0)) level_next = level - PARAM_W'(1);
    end
  end

endmodule

// File: rtl/effect_param_ctrl.sv
// Effect parameter controller: mode FSM, per-slot level editing in SET and preset bank save/load.
module effect_param_ctrl
  import effect_pkg::*;
#(
  parameter int unsigned NUM_EFF    = 8,
  parameter int unsigned PARAM_W    = 3,
  parameter int unsigned NUM_PRESET = 4,
  parameter bit          SAT        = 1'b0,
  parameter logic [NUM_EFF*PARAM_W-1:0] RST_VALS =
    (NUM_EFF*PARAM_W)'(rst_default(NUM_EFF, PARAM_W)),
  localparam int unsigned SelW = (NUM_EFF > 1) ? $clog2(NUM_EFF) : 1,
  localparam int unsigned PreW = (NUM_PRESET > 1) ? $clog2(NUM_PRESET) : 1,
  localparam int unsigned TotW = NUM_EFF * PARAM_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_init_done,
  input  logic               i_key_mode,
  input  logic               i_key_loop,
  input  logic               i_key_inc,
  input  logic               i_key_dec,
  input  logic               i_save,
  input  logic               i_load,
  input  logic [SelW-1:0]    i_sel,
  input  logic [PreW-1:0]    i_preset,
  input  logic [NUM_EFF-1:0] i_en,
  output logic [2:0]         o_state,
  output logic [TotW-1:0]    o_params,
  output logic [PARAM_W-1:0] o_cur_val,
  output logic [8:0]         o_ledg,
  output logic [NUM_EFF-1:0] o_ledr,
  output logic               o_changed
);

  state_e                          state_q, state_d;
  logic [TotW-1:0]                 params_q, params_d, step_out;
  logic [NUM_PRESET-1:0][TotW-1:0] banks_q;
  logic [PARAM_W-1:0]              cur_val_q, cur_val_d;
  logic [8:0]                      ledg_q, ledg_d;
  logic [NUM_EFF-1:0]              ledr_q, ledr_d, sel_hot;
  logic                            changed_q;
  logic                            edit, pre_ok, do_load, do_save, do_step;

  assign edit    = (state_q == StSet);
  assign pre_ok  = {1'b0, i_preset} < (PreW+1)'(NUM_PRESET);
  assign do_load = edit && i_load && pre_ok;
  assign do_save = edit && i_save && !i_load && pre_ok;
  // Any preset pulse drops a simultaneous inc/dec, even when the bank index is invalid.
  assign do_step = edit && !i_load && !i_save;

  for (genvar k = 0; k < NUM_EFF; k++) begin : g_slot
    assign sel_hot[k] = (i_sel == SelW'(k));
    param_step #(
      .PARAM_W (PARAM_W),
      .SAT     (SAT)
    ) u_step (
      .level      (params_q[k*PARAM_W +: PARAM_W]),
      .inc        (do_step && sel_hot[k] && i_key_inc),
      .dec        (do_step && sel_hot[k] && i_key_dec),
      .level_next (step_out[k*PARAM_W +: PARAM_W])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StI2c:   if (i_init_done) state_d = StPlay;
      StPlay: begin
        if (i_key_mode)      state_d = StSet;
        else if (i_key_loop) state_d = StRecd;
      end
      StSet:   if (i_key_mode) state_d = StPlay;
      StRecd:  if (i_key_loop) state_d = StLoop;
      StLoop:  if (i_key_loop) state_d = StPlay;
      default: state_d = StI2c;
    endcase
  end

  always_comb begin
    if (do_load)      params_d = banks_q[i_preset];
    else if (do_step) params_d = step_out;
    else              params_d = params_q;
  end

  // Outputs are computed from next-state values so they appear one clock after the key pulse.
  always_comb begin
    cur_val_d = '0;
    if (state_d == StSet) begin
      for (int k = 0; k < NUM_EFF; k++) begin
        if (sel_hot[k]) cur_val_d = params_d[k*PARAM_W +: PARAM_W];
      end
    end
    ledr_d = (state_d == StSet) ? sel_hot : i_en;
    case (state_d)
      StPlay:  ledg_d = LedPlay;
      StSet:   ledg_d = LedSet;
      StRecd:  ledg_d = LedRecd;
      StLoop:  ledg_d = LedLoop;
      default: ledg_d = LedI2c;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StI2c;
      params_q  <= RST_VALS;
      banks_q   <= {NUM_PRESET{RST_VALS}};
      changed_q <= 1'b0;
      cur_val_q <= '0;
      ledg_q    <= LedI2c;
      ledr_q    <= '0;
    end else begin
      state_q   <= state_d;
      params_q  <= params_d;
      if (do_save) banks_q[i_preset] <= params_q;
      changed_q <= (params_d != params_q);
      cur_val_q <= cur_val_d;
      ledg_q    <= ledg_d;
      ledr_q    <= ledr_d;
    end
  end

  assign o_state   = state_q;
  assign o_params  = params_q;
  assign o_cur_val = cur_val_q;
  assign o_ledg    = ledg_q;
  assign o_ledr    = ledr_q;
  assign o_changed = changed_q;

endmodule

// File: tb/tb_effect_param_ctrl.sv
// Bench for effect_param_ctrl: three configurations (wrap, saturate, 6 slots) checked against a model.
module tb_effect_param_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, init_done, key_mode, key_loop, key_inc, key_dec, save, load;
  logic [2:0] sel;
  logic [1:0] preset;
  logic [7:0] en;

  logic [2:0]  st0, st1, st2;
  logic [23:0] p0, p1;
  logic [17:0] p2;
  logic [2:0]  cv0, cv1, cv2;
  logic [8:0]  lg0, lg1, lg2;
  logic [7:0]  lr0, lr1;
  logic [5:0]  lr2;
  logic        ch0, ch1, ch2;

  int tests = 0;
  int fails = 0;
  bit started = 0;
  int cnt[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  effect_param_ctrl #(.NUM_EFF(8), .PARAM_W(3), .NUM_PRESET(4), .SAT(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done), .i_key_mode(key_mode),
    .i_key_loop(key_loop), .i_key_inc(key_inc), .i_key_dec(key_dec), .i_save(save),
    .i_load(load), .i_sel(sel), .i_preset(preset), .i_en(en), .o_state(st0), .o_params(p0),
    .o_cur_val(cv0), .o_ledg(lg0), .o_ledr(lr0), .o_changed(ch0));

  effect_param_ctrl #(.NUM_EFF(8), .PARAM_W(3), .NUM_PRESET(4), .SAT(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done), .i_key_mode(key_mode),
    .i_key_loop(key_loop), .i_key_inc(key_inc), .i_key_dec(key_dec), .i_save(save),
    .i_load(load), .i_sel(sel), .i_preset(preset), .i_en(en), .o_state(st1), .o_params(p1),
    .o_cur_val(cv1), .o_ledg(lg1), .o_ledr(lr1), .o_changed(ch1));

  effect_param_ctrl #(.NUM_EFF(6), .PARAM_W(3), .NUM_PRESET(4), .SAT(1'b0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done), .i_key_mode(key_mode),
    .i_key_loop(key_loop), .i_key_inc(key_inc), .i_key_dec(key_dec), .i_save(save),
    .i_load(load), .i_sel(sel), .i_preset(preset), .i_en(en[5:0]), .o_state(st2), .o_params(p2),
    .o_cur_val(cv2), .o_ledg(lg2), .o_ledr(lr2), .o_changed(ch2));

  // Reference model: levels as plain integers per slot, state as its numeric code.
  int ne_of[3]  = '{8, 8, 6};
  int sat_of[3] = '{0, 1, 0};
  int m_lvl[3][16];
  int m_bank[3][4][16];
  int m_st[3], m_cur[3], m_ledg[3], m_ledr[3], m_chg[3];
  int old_lvl[16];
  int nst, isel, d, v;

  function automatic int rst_lvl(input int k);
    return (k == 3 || k == 4) ? 3 : 0;
  endfunction

  function automatic int next_code(input int s);
    if (s == 0) return init_done ? 1 : 0;
    if (s == 1) return key_mode ? 2 : (key_loop ? 3 : 1);
    if (s == 2) return key_mode ? 1 : 2;
    if (s == 3) return key_loop ? 4 : 3;
    if (s == 4) return key_loop ? 1 : 4;
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_st[i] = 0; m_chg[i] = 0; m_cur[i] = 0; m_ledg[i] = 256; m_ledr[i] = 0;
        for (int k = 0; k < 16; k++) begin
          m_lvl[i][k] = rst_lvl(k);
          for (int b = 0; b < 4; b++) m_bank[i][b][k] = rst_lvl(k);
        end
      end else begin
        for (int k = 0; k < 16; k++) old_lvl[k] = m_lvl[i][k];
        isel = int'(sel);
        if (m_st[i] == 2) begin
          if (load) begin
            for (int k = 0; k < 16; k++) m_lvl[i][k] = m_bank[i][preset][k];
          end else if (save) begin
            for (int k = 0; k < 16; k++) m_bank[i][preset][k] = m_lvl[i][k];
          end else if (isel < ne_of[i]) begin
            d = int'(key_inc) - int'(key_dec);
            v = m_lvl[i][isel] + d;
            if (sat_of[i] != 0) v = (v < 0) ? 0 : ((v > 7) ? 7 : v);
            else v = (v + 8) % 8;
            m_lvl[i][isel] = v;
          end
        end
        nst = next_code(m_st[i]);
        m_chg[i] = 0;
        for (int k = 0; k < 16; k++) if (old_lvl[k] != m_lvl[i][k]) m_chg[i] = 1;
        m_st[i]   = nst;
        m_cur[i]  = (nst == 2 && isel < ne_of[i]) ? m_lvl[i][isel] : 0;
        m_ledg[i] = (nst == 0) ? 256 : (1 << (nst - 1));
        if (nst == 2) m_ledr[i] = (isel < ne_of[i]) ? (1 << isel) : 0;
        else          m_ledr[i] = int'(en) & ((1 << ne_of[i]) - 1);
      end
    end
    started = 1;
  end

  function automatic int exp_params(input int i);
    int r = 0;
    for (int k = 0; k < ne_of[i]; k++) r += m_lvl[i][k] << (3 * k);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("d0.state", 32'(st0), m_st[0]);   check("d1.state", 32'(st1), m_st[1]);
      check("d2.state", 32'(st2), m_st[2]);
      check("d0.params", 32'(p0), exp_params(0)); check("d1.params", 32'(p1), exp_params(1));
      check("d2.params", 32'(p2), exp_params(2));
      check("d0.cur", 32'(cv0), m_cur[0]);    check("d1.cur", 32'(cv1), m_cur[1]);
      check("d2.cur", 32'(cv2), m_cur[2]);
      check("d0.ledg", 32'(lg0), m_ledg[0]);  check("d1.ledg", 32'(lg1), m_ledg[1]);
      check("d2.ledg", 32'(lg2), m_ledg[2]);
      check("d0.ledr", 32'(lr0), m_ledr[0]);  check("d1.ledr", 32'(lr1), m_ledr[1]);
      check("d2.ledr", 32'(lr2), m_ledr[2]);
      check("d0.changed", 32'(ch0), m_chg[0]); check("d1.changed", 32'(ch1), m_chg[1]);
      check("d2.changed", 32'(ch2), m_chg[2]);
      cnt[0] += int'(ch0); cnt[1] += int'(ch1); cnt[2] += int'(ch2);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_keys();
    init_done = 0; key_mode = 0; key_loop = 0; key_inc = 0; key_dec = 0; save = 0; load = 0;
  endtask

  int base0, base1, base2;

  initial begin
    rst_n = 0; clear_keys(); sel = 0; preset = 0; en = 8'h00;
    cyc(); cyc();
    check("rst.state", 32'(st0), 0);
    check("rst.ledg", 32'(lg0), 32'h100);
    check("rst.params", 32'(p0), 32'h3600);
    check("rst.ledr", 32'(lr0), 0);
    rst_n = 1;

    init_done = 1; cyc(); clear_keys();
    check("init.state", 32'(st0), 1);
    check("init.params", 32'(p0), 32'h3600);
    en = 8'hA5; cyc();
    check("play.ledr8", 32'(lr0), 32'hA5);
    check("play.ledr6", 32'(lr2), 32'h25);

    // Eight increments on slot 2: wrap returns to 0, saturate stops at 7.
    key_mode = 1; cyc(); clear_keys();
    sel = 2; base0 = cnt[0]; base1 = cnt[1]; base2 = cnt[2];
    key_inc = 1; repeat (8) cyc(); clear_keys();
    check("inc8.wrap_params", 32'(p0), 32'h3600);
    check("inc8.wrap_pulses", 32'(cnt[0] - base0), 8);
    check("inc8.sat_params", 32'(p1), 32'h37C0);
    check("inc8.sat_pulses", 32'(cnt[1] - base1), 7);
    check("inc8.n6_pulses", 32'(cnt[2] - base2), 8);

    // Save bank 1, decrement slot 0, restore from bank 1.
    sel = 0; preset = 1; save = 1; cyc(); clear_keys();
    key_dec = 1; cyc(); clear_keys();
    check("dec.wrap", 32'(p0), 32'h3607);
    check("dec.sat", 32'(p1), 32'h37C0);
    load = 1; cyc(); clear_keys();
    check("load.params", 32'(p0), 32'h3600);
    check("load.changed", 32'(ch0), 1);

    // load + save + inc together: only the load lands.
    key_inc = 1; cyc(); clear_keys();
    check("inc.slot0", 32'(p0), 32'h3601);
    load = 1; save = 1; key_inc = 1; cyc(); clear_keys();
    check("prio.params", 32'(p0), 32'h3600);
    key_inc = 1; key_dec = 1; cyc(); clear_keys();
    check("incdec.params", 32'(p0), 32'h3600);
    check("incdec.changed", 32'(ch0), 0);

    // Edit and leave SET in the same cycle.
    key_mode = 1; key_inc = 1; cyc(); clear_keys();
    check("modeinc.params", 32'(p0), 32'h3601);
    check("modeinc.state", 32'(st0), 1);
    check("modeinc.cur", 32'(cv0), 0);

    key_mode = 1; key_loop = 1; cyc(); clear_keys();
    check("modeloop.state", 32'(st0), 2);
    key_mode = 1; cyc(); clear_keys();
    key_loop = 1; cyc(); clear_keys();
    check("recd.state", 32'(st0), 3);
    key_loop = 1; cyc(); clear_keys();
    check("loop.state", 32'(st0), 4);
    check("loop.ledg", 32'(lg0), 32'h008);
    key_inc = 1; cyc(); clear_keys();
    check("loop.inc_ignored", 32'(p0), 32'h3601);
    key_loop = 1; cyc(); clear_keys();
    check("loop.back", 32'(st0), 1);

    // Out-of-range select on the 6-slot instance.
    key_mode = 1; cyc(); clear_keys();
    sel = 7; key_inc = 1; cyc(); clear_keys();
    check("n6.sel7_params", 32'(p2), 32'h3601);
    check("n6.sel7_cur", 32'(cv2), 0);
    check("n6.sel7_ledr", 32'(lr2), 0);
    check("n8.sel7_cur", 32'(cv0), 1);
    check("n8.sel7_ledr", 32'(lr0), 32'h80);

    // Reset in the middle of an edit wipes live levels and banks.
    sel = 3; key_inc = 1; rst_n = 0; cyc(); clear_keys();
    check("midrst.params", 32'(p0), 32'h3600);
    check("midrst.state", 32'(st0), 0);
    rst_n = 1;
    init_done = 1; cyc(); clear_keys();
    key_mode = 1; cyc(); clear_keys();
    preset = 1; load = 1; cyc(); clear_keys();
    check("rstbank.sat_params", 32'(p1), 32'h3600);
    check("rstbank.changed", 32'(ch1), 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/effect_param_ctrl.md
EFFECT_PARAM_CTRL -- requirements
Module: effect_param_ctrl

Interface
REQ-001 SHALL have parameter NUM_EFF, default 8, meaning number of effect slots (2..16).
REQ-002 SHALL have parameter PARAM_W, default 3, meaning width of each effect level.
REQ-003 SHALL have parameter NUM_PRESET, default 4, meaning number of preset banks (1..8).
REQ-004 SHALL have parameter SAT, default 0, meaning 0 = wrap on inc/dec, 1 = saturate at 0 and 2^PARAM_W-1.
REQ-005 SHALL have parameter RST_VALS, default all 0 except slots 3 and 4 = 3, meaning packed NUM_EFF*PARAM_W reset levels.
REQ-006 i_clk  in  1  sole clock (audio bit clock domain).
REQ-007 i_rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-008 i_init_done  in  1  codec init finished (level).
REQ-009 i_key_mode, i_key_loop, i_key_inc, i_key_dec  in  1 each  single-cycle debounced key pulses.
REQ-010 i_save, i_load  in  1 each  single-cycle preset pulses.
REQ-011 i_sel  in  $clog2(NUM_EFF)  selected effect slot.
REQ-012 i_preset  in  $clog2(NUM_PRESET) (min 1)  selected preset bank.
REQ-013 i_en  in  NUM_EFF  effect enable switches.
REQ-014 o_state  out  3  current FSM state code.
REQ-015 o_params  out  NUM_EFF*PARAM_W  packed live levels, slot k at [k*PARAM_W +: PARAM_W].
REQ-016 o_cur_val  out  PARAM_W  level of selected slot in SET, else 0.
REQ-017 o_ledg  out  9  state indicator; o_ledr  out  NUM_EFF  effect indicator.
REQ-018 o_changed  out  1  one-cycle pulse whenever any live level changes.

Function
REQ-019 FSM states SHALL be I2C=0, PLAY=1, SET=2, RECD=3, LOOP=4; all outputs registered, 1-cycle latency from key pulse.
REQ-020 Transitions: I2C->PLAY on i_init_done; PLAY->SET on mode, else PLAY->RECD on loop; SET->PLAY on mode; RECD->LOOP on loop; LOOP->PLAY on loop; mode beats loop when simultaneous; codes 5-7 SHALL return to I2C.
REQ-021 Level edits (inc/dec/save/load) SHALL act only in SET; ignored in all other states.
REQ-022 inc adds 1, dec subtracts 1 to slot i_sel; inc and dec together SHALL leave level unchanged and not pulse o_changed.
REQ-023 SAT=0: 2^PARAM_W-1 +1 -> 0, 0 -1 -> max; SAT=1: clamp, no o_changed when clamped.
REQ-024 i_sel >= NUM_EFF SHALL ignore inc/dec and drive o_cur_val = 0.
REQ-025 save SHALL copy all live levels into bank i_preset in one cycle; load SHALL copy bank i_preset into live levels in one cycle and pulse o_changed if any differ.
REQ-026 Priority per cycle: load > save > inc/dec; lower-priority requests that cycle are dropped.
REQ-027 o_ledg one-hot: I2C bit 8, PLAY bit 0, SET bit 1, RECD bit 2, LOOP bit 3.
REQ-028 o_ledr = one-hot of i_sel in SET (zero if out of range), else i_en.
REQ-029 State change and level edit in same cycle (mode + inc in SET) SHALL apply the edit, then leave SET.

Reset
REQ-030 On i_clk edge with i_rst_n=0: state I2C, live levels = RST_VALS, every preset bank = RST_VALS, o_changed=0, o_cur_val=0, o_ledg=9'h100, o_ledr=0.
REQ-031 Reset mid-edit SHALL discard any pending edit; reset dominates all inputs.

Structure
REQ-032 State codes, LED one-hot constants and default RST_VALS SHALL live in shared package effect_pkg.
REQ-033 One sub-module natural: param_step (single-slot inc/dec with wrap/saturate, combinational), instantiated NUM_EFF times.

Verification
REQ-034 Reset, i_init_done=1 one cycle -> o_state 1, o_params slot3=slot4=3, others 0.
REQ-035 SET, i_sel=2, eight inc pulses, SAT=0 -> slot2 returns to 0, eight o_changed pulses; SAT=1 -> slot2=7, seven pulses.
REQ-036 SET, save to bank 1, dec slot0 (SAT=0 -> 7), load bank 1 -> slot0=0, o_changed on load.
REQ-037 Same cycle load+save+inc -> only load applied; inc+dec together -> no change, no pulse.
REQ-038 PLAY, mode+loop together -> SET; in LOOP, inc -> levels unchanged; loop -> PLAY.
REQ-039 i_sel=9 with NUM_EFF=8... use NUM_EFF=6, i_sel=7 in SET, inc -> no change, o_cur_val=0, o_ledr=0.
